// File: rtl/axi4_sram_responder_pkg.sv
// Shared types for the AXI4 SRAM responder: burst encodings, FSM states and
// the per-beat address step.
package axi4_sram_responder_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // WRAP and the reserved encoding step like INCR; callers truncate to their
  // address width, which gives modulo-2^AW wrap for free.
  function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst);
    logic [63:0] step;
    step = 64'd1 << size;
    case (burst)
      BURST_FIXED:            next_addr = addr;
      BURST_INCR, BURST_WRAP: next_addr = addr + step;
      default:                next_addr = addr + step;
    endcase
  endfunction

endpackage

// File: rtl/axi4_sram_bank.sv
// DEPTH x 64-bit flop array: one byte-strobed write port, one combinational
// read port. Contents are deliberately not reset.
module axi4_sram_bank #(
  parameter int DEPTH = 256,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IDXW-1:0] widx,
  input  logic [63:0]     wdata,
  input  logic [7:0]      wstrb,
  input  logic [IDXW-1:0] ridx,
  output logic [63:0]     rdata
);

  logic [63:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // A read of the word being written this cycle still sees the old value.
  assign rdata = mem_q[ridx];

endmodule

// File: rtl/axi4_sram_responder.sv
// AXI4 responder backed by a flop-array scratch memory. Independent write
// (AW/W/B) and read (AR/R) state machines, one outstanding burst each.
module axi4_sram_responder
  import axi4_sram_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDW   = 4,
  parameter int AW    = 31
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           auto_in_aw_valid,
  output logic           auto_in_aw_ready,
  input  logic [IDW-1:0] auto_in_aw_id,
  input  logic [AW-1:0]  auto_in_aw_addr,
  input  logic [7:0]     auto_in_aw_len,
  input  logic [2:0]     auto_in_aw_size,
  input  logic [1:0]     auto_in_aw_burst,
  input  logic           auto_in_aw_lock,
  input  logic [3:0]     auto_in_aw_cache,
  input  logic [2:0]     auto_in_aw_prot,
  input  logic [3:0]     auto_in_aw_qos,
  input  logic           auto_in_w_valid,
  output logic           auto_in_w_ready,
  input  logic [63:0]    auto_in_w_data,
  input  logic [7:0]     auto_in_w_strb,
  input  logic           auto_in_w_last,
  output logic           auto_in_b_valid,
  input  logic           auto_in_b_ready,
  output logic [IDW-1:0] auto_in_b_id,
  input  logic           auto_in_ar_valid,
  output logic           auto_in_ar_ready,
  input  logic [IDW-1:0] auto_in_ar_id,
  input  logic [AW-1:0]  auto_in_ar_addr,
  input  logic [7:0]     auto_in_ar_len,
  input  logic [2:0]     auto_in_ar_size,
  input  logic [1:0]     auto_in_ar_burst,
  input  logic           auto_in_ar_lock,
  input  logic [3:0]     auto_in_ar_cache,
  input  logic [2:0]     auto_in_ar_prot,
  input  logic [3:0]     auto_in_ar_qos,
  output logic           auto_in_r_valid,
  input  logic           auto_in_r_ready,
  output logic [IDW-1:0] auto_in_r_id,
  output logic [63:0]    auto_in_r_data,
  output logic           auto_in_r_last,
  output w_state_e       dbg_w_state,
  output r_state_e       dbg_r_state
);

  // Handshakes: a transfer happens on a rising clock edge where valid and
  // ready are both high; the source holds valid and payload stable until then.

  localparam int IDXW = $clog2(DEPTH);

  w_state_e       w_state_q, w_state_d;
  logic [IDW-1:0] w_id_q, w_id_d, bid_q, bid_d;
  logic [AW-1:0]  w_addr_q, w_addr_d;
  logic [7:0]     w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]     w_size_q, w_size_d;
  logic [1:0]     w_burst_q, w_burst_d;
  logic           awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic           mem_we;

  r_state_e       r_state_q, r_state_d;
  logic [IDW-1:0] rid_q, rid_d;
  logic [AW-1:0]  r_addr_q, r_addr_d;
  logic [7:0]     r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]     r_size_q, r_size_d;
  logic [1:0]     r_burst_q, r_burst_d;
  logic           arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: if (auto_in_aw_valid && awready_q) begin
        w_id_d    = auto_in_aw_id;
        w_addr_d  = auto_in_aw_addr;
        w_len_d   = auto_in_aw_len;
        w_size_d  = auto_in_aw_size;
        w_burst_d = auto_in_aw_burst;
        w_cnt_d   = '0;
        awready_d = 1'b0;
        wready_d  = 1'b1;
        w_state_d = W_DATA;
      end
      W_DATA: if (auto_in_w_valid && wready_q) begin
        mem_we   = 1'b1;
        w_addr_d = AW'(next_addr(64'(w_addr_q), w_size_q, w_burst_q));
        w_cnt_d  = w_cnt_q + 8'd1;
        // Beat count alone ends the burst; wlast is not trusted.
        if (w_cnt_q == w_len_q) begin
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bid_d     = w_id_q;
          w_state_d = W_RESP;
        end
      end
      W_RESP: if (auto_in_b_ready) begin
        bvalid_d  = 1'b0;
        awready_d = 1'b1;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      R_IDLE: if (auto_in_ar_valid && arready_q) begin
        rid_d     = auto_in_ar_id;
        r_addr_d  = auto_in_ar_addr;
        r_len_d   = auto_in_ar_len;
        r_size_d  = auto_in_ar_size;
        r_burst_d = auto_in_ar_burst;
        r_cnt_d   = '0;
        arready_d = 1'b0;
        rvalid_d  = 1'b1;
        rlast_d   = (auto_in_ar_len == 8'd0);
        r_state_d = R_DATA;
      end
      R_DATA: if (auto_in_r_ready) begin
        r_addr_d = AW'(next_addr(64'(r_addr_q), r_size_q, r_burst_q));
        r_cnt_d  = r_cnt_q + 8'd1;
        if (rlast_q) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end else begin
          rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  axi4_sram_bank #(.DEPTH(DEPTH)) u_bank (
    .clk   (clock),
    .we    (mem_we),
    .widx  (w_addr_q[IDXW+2:3]),
    .wdata (auto_in_w_data),
    .wstrb (auto_in_w_strb),
    .ridx  (r_addr_q[IDXW+2:3]),
    .rdata (auto_in_r_data)
  );

  assign auto_in_aw_ready = awready_q;
  assign auto_in_w_ready  = wready_q;
  assign auto_in_b_valid  = bvalid_q;
  assign auto_in_b_id     = bid_q;
  assign auto_in_ar_ready = arready_q;
  assign auto_in_r_valid  = rvalid_q;
  assign auto_in_r_id     = rid_q;
  assign auto_in_r_last   = rlast_q;
  assign dbg_w_state      = w_state_q;
  assign dbg_r_state      = r_state_q;

  logic unused_ok;
  assign unused_ok = ^{auto_in_aw_lock, auto_in_aw_cache, auto_in_aw_prot, auto_in_aw_qos,
                       auto_in_ar_lock, auto_in_ar_cache, auto_in_ar_prot, auto_in_ar_qos,
                       auto_in_w_last, w_addr_q, r_addr_q};

endmodule

// File: doc/axi4_sram_responder.md
Name: axi4_sram_responder

Overview:
- AXI4 subordinate (responder) terminating the ID-widened master-side channel that leaves the ID indexer.
- Accepts AW/W/AR bursts and returns B/R beats carrying the 4-bit ID unchanged, backed by a flop-array memory of 64-bit words.
- Used as a simulation/boot scratch memory behind the crossbar; no response-code channel exists on this interface.

Parameters:
- DEPTH, 256, number of 64-bit words; power of two, at least 2.
- IDW, 4, AXI ID width.
- AW, 31, address width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- auto_in_aw{valid,ready,id,addr,len,size,burst,lock,cache,prot,qos}  in/out(ready)  1,1,IDW,AW,8,3,2,1,4,3,4  write address channel; lock/cache/prot/qos are ignored
- auto_in_w{valid,ready,data,strb,last}  in/out(ready)  1,1,64,8,1  write data channel
- auto_in_b{valid,ready,id}  out/in(ready)/out  1,1,IDW  write response
- auto_in_ar{valid,ready,id,addr,len,size,burst,lock,cache,prot,qos}  in/out(ready)  same widths as AW  read address channel
- auto_in_r{valid,ready,id,data,last}  out/in(ready)/out/out/out  1,1,IDW,64,1  read data

Behaviour:
- Reset (reset=0, asynchronous): both FSMs go to IDLE. awready=1, arready=1; wready, bvalid, rvalid, rlast=0; bid, rid=0. Memory contents are not reset.
- Word index is (addr >> 3) mod DEPTH. Upper bits alias silently.
- Beat address step: INCR (burst=1) adds 1<<size; FIXED (burst=0) keeps the address; WRAP (2) and reserved (3) are treated as INCR.
- Address arithmetic is AW bits wide and wraps modulo 2^AW.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1. On awvalid, capture id/addr/len/size/burst, clear beat count, go to W_DATA next cycle.
  - W_DATA: wready=1. Each wvalid&wready writes the byte lanes of mem[idx] where wstrb is set; the write is visible from the next cycle. Then advance the address and increment the count.
  - The burst ends on the beat where count==len. wlast is ignored for termination, so an early or missing wlast does not change the beat count. Then go to W_RESP.
  - W_RESP: bvalid=1, bid=captured id. Hold until bready, then return to W_IDLE. Minimum AW-handshake to B-valid latency is len+2 cycles.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On arvalid, capture fields, clear count, go to R_DATA.
  - R_DATA: rvalid=1, rid=captured id, rdata=mem[current idx] (combinational from the array), rlast=(count==len).
  - On rready: advance the address and count. If rlast, return to R_IDLE.
  - First R beat is valid the cycle after the AR handshake.
- Read and write FSMs are fully independent and may run concurrently.
- Same-word collision: a read beat in the same cycle as a write to that word returns the old data. A read in any later cycle returns the new data.
- awready is high only in W_IDLE; there is no AW queueing, so a second AW stalls until B completes. The same holds for AR.
- Stall rules: valid outputs and their payload stay stable while ready is low. rdata may change while rvalid && !rready only if a write to that word commits.
- len=0 gives single-beat bursts. len=255 gives 256 beats, with an 8-bit count and no overflow past len.
- A reset deasserted mid-burst restarts cleanly in IDLE. Any in-flight burst is dropped.

Decomposition:
- Shared package holds: the burst encodings (FIXED=0, INCR=1, WRAP=2); the write state enum {W_IDLE, W_DATA, W_RESP}; the read state enum {R_IDLE, R_DATA}; and the function next_addr(addr, size, burst).
- One natural sub-module: axi4_sram_bank, a DEPTH×64 flop array with a byte-strobed write port and one combinational read port. The top holds both FSMs.

Test Plan:
- Single write then read: AW id=5 addr=0x100 len=0 size=3, W data=0xDEADBEEF_CAFEF00D strb=0xFF. Required: B with bid=5 two cycles after AW; then AR id=9 addr=0x100 len=0 returns rid=9, rdata=0xDEADBEEF_CAFEF00D, rlast=1.
- INCR burst: write len=3 at 0x200 with data 1,2,3,4, then read len=3. Required: 4 R beats 1,2,3,4, with rlast only on beat 4.
- FIXED burst and strobes: write len=1 burst=0 at 0x40 with data 0x11..11 strb=0xFF then 0x22..22 strb=0x0F; read back. Required: 0x11111111_22222222.
- Backpressure: read len=3 with rready toggling 1,0,0,1,1,0,1. Required: rvalid held and payload stable during stalls; exactly 4 handshakes. Repeat with bready held low for 5 cycles: bvalid stays 1 and awready stays 0.
- Concurrent and collision: write to word 0x300 in the same cycle as a read beat of 0x300 (old value 0xAA). Required: read returns 0xAA, and a subsequent read returns the new data.
- Reset mid-burst: pull reset low during beat 2 of a len=7 read. Required: rvalid=0 immediately and arready=1 after release. Also check wlast asserted early on beat 1 of a len=2 write: B is issued only after 3 beats.
